// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the 2:1 mux primitive the full-subtractor cell is built from.
package serial_sub_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic mux2(input logic sel, input logic in0, input logic in1);
        return sel ? in1 : in0;
    endfunction

endpackage

// File: rtl/fs_bit_cell.sv
// Combinational 1-bit full subtractor (x - y - bi) assembled from 2:1 muxes.
module fs_bit_cell
    import serial_sub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bout
);

    logic x_ne_y;

    assign x_ne_y = mux2(y, x, ~x);
    assign diff   = mux2(bi, x_ne_y, ~x_ne_y);
    // When the operand bits differ a borrow happens exactly when y=1; otherwise it propagates.
    assign bout   = mux2(x_ne_y, bi, y);

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial N-bit subtractor: d = a - b - bin, LSB first, one full-subtractor
// cell and a registered borrow, plus a<b / a==b flags from the final result.
module serial_sub_unit
    import serial_sub_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int CW = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bo,
    output logic         a_lt_b,
    output logic         a_eq_b,
    output state_t       state_dbg
);

    state_t        state, state_next;
    logic [N-1:0]  sa, sb, res, res_shift;
    logic          br, dbit, bnext, last;
    logic [CW-1:0] cnt;

    fs_bit_cell u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bi   (br),
        .diff (dbit),
        .bout (bnext)
    );

    assign last      = (cnt == CW'(N - 1));
    assign state_dbg = state;

    // Result register fills from the MSB end so the LSB lands at bit 0 after N shifts.
    always_comb begin
        res_shift        = res >> 1;
        res_shift[N-1]   = dbit;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (last) state_next = ST_DONE;
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            bo     <= 1'b0;
            a_lt_b <= 1'b0;
            a_eq_b <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= bin;
                        cnt <= '0;
                        res <= '0;
                    end
                end
                ST_RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_shift;
                    br  <= bnext;
                    // The counter parks at N-1; the last bit publishes the result.
                    if (!last) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        d      <= res_shift;
                        bo     <= bnext;
                        a_lt_b <= bnext;
                        a_eq_b <= (res_shift == '0) && !bnext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed bench for serial_sub_unit at N=4 and N=1 against an arithmetic model.
module tb_serial_sub_unit;
    import serial_sub_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // N=4 instance signals
    logic       start4, bin4, busy4, done4, bo4, lt4, eq4;
    logic [3:0] a4, b4, d4;
    state_t     st4;
    // N=1 instance signals
    logic       start1, a1, b1, bin1, busy1, done1, d1, bo1, lt1, eq1;
    state_t     st1;

    always #5 clk = ~clk;

    serial_sub_unit #(.N(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4), .bo(bo4), .a_lt_b(lt4), .a_eq_b(eq4),
        .state_dbg(st4)
    );

    serial_sub_unit #(.N(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .d(d1), .bo(bo1), .a_lt_b(lt1), .a_eq_b(eq1),
        .state_dbg(st1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Plain integer subtraction; returns {borrow, 4-bit difference mod 2^n}.
    function automatic logic [4:0] sub_model(input int x, input int y, input int bi, input int n);
        int r;
        int m;
        int dd;
        r  = x - y - bi;
        m  = 1 << n;
        dd = (r + m) % m;
        return {(r < 0), 4'(dd)};
    endfunction

    // Model: an accepted start keeps the unit busy for n+1 cycles; the last one is done.
    logic [4:0] exp4_q[$];
    logic [1:0] exp1_q[$];
    int         m4_left, m1_left;
    logic [3:0] m4_d;
    logic       m4_bo, m4_eq, m1_d, m1_bo, m1_eq;
    logic [4:0] r4, r5;
    logic [1:0] r1;

    always @(posedge clk) begin
        if (rst) begin
            m4_left <= 0; m4_d <= '0; m4_bo <= 1'b0; m4_eq <= 1'b0;
            exp4_q.delete();
        end else if (m4_left > 0) begin
            m4_left <= m4_left - 1;
            if (m4_left == 2) begin
                r4 = exp4_q.pop_front();
                m4_d  <= r4[3:0];
                m4_bo <= r4[4];
                m4_eq <= (r4 == 5'd0);
            end
        end else if (start4) begin
            exp4_q.push_back(sub_model(int'(a4), int'(b4), int'(bin4), 4));
            m4_left <= 5;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m1_left <= 0; m1_d <= 1'b0; m1_bo <= 1'b0; m1_eq <= 1'b0;
            exp1_q.delete();
        end else if (m1_left > 0) begin
            m1_left <= m1_left - 1;
            if (m1_left == 2) begin
                r1 = exp1_q.pop_front();
                m1_d  <= r1[0];
                m1_bo <= r1[1];
                m1_eq <= (r1 == 2'd0);
            end
        end else if (start1) begin
            r5 = sub_model(int'(a1), int'(b1), int'(bin1), 1);
            exp1_q.push_back({r5[4], r5[0]});
            m1_left <= 2;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy4",  int'(busy4), int'(m4_left > 0));
            chk("done4",  int'(done4), int'(m4_left == 1));
            chk("d4",     int'(d4),    int'(m4_d));
            chk("bo4",    int'(bo4),   int'(m4_bo));
            chk("lt4",    int'(lt4),   int'(m4_bo));
            chk("eq4",    int'(eq4),   int'(m4_eq));
            chk("busy1",  int'(busy1), int'(m1_left > 0));
            chk("done1",  int'(done1), int'(m1_left == 1));
            chk("d1",     int'(d1),    int'(m1_d));
            chk("bo1",    int'(bo1),   int'(m1_bo));
            chk("lt1",    int'(lt1),   int'(m1_bo));
            chk("eq1",    int'(eq1),   int'(m1_eq));
        end
    end

    // One operation with literal expectations; latency counted in edges after acceptance.
    task automatic run_op(input int n, input logic [3:0] av, input logic [3:0] bv, input logic bi,
                          input logic [3:0] ed, input logic ebo, input logic eeq, input string nm);
        int   k;
        int   busy_n;
        logic cb, cdn, cbo, clt, ceq;
        logic [3:0] cd;
        @(posedge clk); #1;
        if (n == 4) begin start4 = 1'b1; a4 = av; b4 = bv; bin4 = bi; end
        else begin start1 = 1'b1; a1 = av[0]; b1 = bv[0]; bin1 = bi; end
        @(posedge clk); #1;
        start4 = 1'b0; start1 = 1'b0;
        a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15)); bin4 = 1'($urandom_range(0, 1));
        a1 = 1'($urandom_range(0, 1));  b1 = 1'($urandom_range(0, 1));  bin1 = 1'($urandom_range(0, 1));
        busy_n = (n == 4) ? int'(busy4) : int'(busy1);
        for (k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            cb  = (n == 4) ? busy4 : busy1;
            cdn = (n == 4) ? done4 : done1;
            if (cb) busy_n++;
            if (cdn) break;
        end
        cd  = (n == 4) ? d4  : {3'b000, d1};
        cbo = (n == 4) ? bo4 : bo1;
        clt = (n == 4) ? lt4 : lt1;
        ceq = (n == 4) ? eq4 : eq1;
        chk({nm, "_latency"}, k, n);
        chk({nm, "_busy_cycles"}, busy_n, n + 1);
        chk({nm, "_d"}, int'(cd), int'(ed));
        chk({nm, "_bo"}, int'(cbo), int'(ebo));
        chk({nm, "_lt"}, int'(clt), int'(ebo));
        chk({nm, "_eq"}, int'(ceq), int'(eeq));
    endtask

    logic [1:0] fs_tab [8];
    int         dn, first_k, dn_rst;
    logic [3:0] first_d;
    logic       gap_busy;

    initial begin
        fs_tab = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_busy4", int'(busy4), 0);
        chk("rst_done4", int'(done4), 0);
        chk("rst_d4", int'(d4), 0);
        chk("rst_state4", int'(st4), int'(ST_IDLE));
        chk("rst_busy1", int'(busy1), 0);
        rst = 1'b0;

        run_op(4, 4'd5,  4'd3, 1'b0, 4'd2,  1'b0, 1'b0, "5m3");
        run_op(4, 4'd3,  4'd5, 1'b0, 4'd14, 1'b1, 1'b0, "3m5");
        run_op(4, 4'd9,  4'd9, 1'b0, 4'd0,  1'b0, 1'b1, "9m9");
        run_op(4, 4'd0,  4'd0, 1'b1, 4'd15, 1'b1, 1'b0, "0m0b");
        run_op(4, 4'd15, 4'd0, 1'b1, 4'd14, 1'b0, 1'b0, "15m0b");

        // start held high through an operation: ignored while busy, re-accepted in IDLE
        @(posedge clk); #1;
        start4 = 1'b1; a4 = 4'd5; b4 = 4'd3; bin4 = 1'b0;
        @(posedge clk); #1;
        a4 = 4'd1; b4 = 4'd1;
        dn = 0; first_k = 0; first_d = '0; gap_busy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 5) gap_busy = busy4;
            if (done4) begin
                dn++;
                if (dn == 1) begin first_k = k; first_d = d4; end
            end
        end
        start4 = 1'b0;
        chk("held_done_count", dn, 2);
        chk("held_first_latency", first_k, 4);
        chk("held_first_d", int'(first_d), 2);
        chk("held_gap_busy", int'(gap_busy), 0);
        chk("held_second_d", int'(d4), 0);
        chk("held_second_eq", int'(eq4), 1);

        // reset during the second RUN cycle aborts and clears the outputs
        run_op(4, 4'd12, 4'd1, 1'b0, 4'd11, 1'b0, 1'b0, "12m1");
        @(posedge clk); #1;
        start4 = 1'b1; a4 = 4'd7; b4 = 4'd2; bin4 = 1'b0;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", int'(busy4), 0);
        chk("abort_d", int'(d4), 0);
        chk("abort_done", int'(done4), 0);
        dn_rst = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done4) dn_rst++;
        end
        chk("abort_no_done", dn_rst, 0);
        run_op(4, 4'd7, 4'd2, 1'b0, 4'd5, 1'b0, 1'b0, "7m2");

        // N=1: full-subtractor truth table indexed by {a,b,bin}
        for (int i = 0; i < 8; i++) begin
            logic [2:0] idx;
            idx = 3'(i);
            run_op(1, {3'b000, idx[2]}, {3'b000, idx[1]}, idx[0],
                   {3'b000, fs_tab[i][1]}, fs_tab[i][0], (fs_tab[i] == 2'b00), "fs1");
        end

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
